// File: rtl/fft_spi_pkg.sv
// Shared definitions for the FFT SPI link (fft_spi_out transmitter and fft_spi_in receiver).
package fft_spi_pkg;

  localparam int FRAME_BITS_DEF = 256;
  localparam int BIN_WIDTH      = 16;
  localparam int SPI_MODE       = 0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, plus an edge detector on the
// synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/fft_spi_in.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS and delivers one
// FRAME_BITS-wide frame per CS-low period, with valid/error strobes.
module fft_spi_in
  import fft_spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int              CW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0]   FULL       = CW'(FRAME_BITS);
  localparam int              ARM_CYCLES = SYNC_STAGES + 1;
  localparam int              AW         = $clog2(ARM_CYCLES + 1);
  localparam logic [AW-1:0]   ARM_LAST   = AW'(ARM_CYCLES);

  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, sclk_fall, mosi_rise, mosi_fall, cs_level};

  spi_state_t              state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CW-1:0]           count_q;
  logic                    ovf_q;
  logic                    pend_q;
  logic [AW-1:0]           arm_q;
  logic                    armed;
  logic                    start, accept, reject;

  // A CS pin held low through reset shows up as a fall once the synchronizer
  // settles; ignoring falls until then keeps partial frames out.
  assign armed = (arm_q == ARM_LAST);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    start   = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && (cs_fall || pend_q)) begin
          start   = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        busy = 1'b1;
        if (cs_rise) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (count_q == FULL && !ovf_q) accept = 1'b1;
        else                           reject = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      arm_q       <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_valid <= accept;
      frame_error <= reject;
      if (accept) data_out <= shift_q;
      if (!armed) arm_q <= arm_q + 1'b1;

      // A fall arriving during DONE is held for the following IDLE cycle.
      if (state_q == DONE && cs_fall && armed) pend_q <= 1'b1;
      else if (state_q == IDLE)                pend_q <= 1'b0;

      if (start) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (state_q == RECV && sclk_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], mosi_level};
        if (count_q == FULL) ovf_q   <= 1'b1;
        else                 count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_spi_in.sv
// Randomized scoreboard bench for fft_spi_in: a high-level frame model queues the
// expected strobe per CS period and a monitor compares each strobe it observes.
module tb_fft_spi_in;

  localparam int FB   = 256;
  localparam int SS   = 2;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sclk;
  logic          mosi;
  logic          cs;
  logic [FB-1:0] data_out;
  logic          frame_valid;
  logic          frame_error;
  logic          busy;

  fft_spi_in #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs(cs),
    .data_out(data_out), .frame_valid(frame_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #31 clk = ~clk;

  typedef struct {
    logic          isValid;
    logic [FB-1:0] data;
    int            id;
  } exp_t;

  exp_t          expQ[$];
  int            checks     = 0;
  int            failures   = 0;
  int            strobes    = 0;
  int            pushed     = 0;
  int            frameId    = 0;
  int            stabBad    = 0;
  logic [FB-1:0] lastGood   = '0;
  logic [FB-1:0] prevData   = '0;
  logic          prevRst    = 1'b0;

  task automatic checkOutput(input string name, input logic [FB-1:0] actual,
                             input logic [FB-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sendBit(input logic b, input logic raiseCs);
    mosi = b;
    waitClk(HALF);
    sclk = 1'b1;
    if (raiseCs) cs = 1'b1;
    waitClk(HALF);
    sclk = 1'b0;
  endtask

  // Model: a CS period of exactly FB bits yields a valid strobe carrying the
  // first bit at the MSB; any other length yields an error and keeps old data.
  task automatic applyStimulus(input logic [FB-1:0] word, input int nbits,
                               input logic coincide, input int gap);
    exp_t e;
    e.id = frameId++;
    if (nbits == FB) begin
      e.isValid = 1'b1;
      e.data    = word;
      lastGood  = word;
    end else begin
      e.isValid = 1'b0;
      e.data    = lastGood;
    end
    expQ.push_back(e);
    pushed++;
    cs = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nbits; i++) begin
      sendBit((i < FB) ? word[FB-1-i] : 1'($urandom_range(0, 1)),
              coincide && (i == nbits - 1));
      if (i == 8) begin
        @(negedge clk);
        checkOutput("busy_mid_frame", busy, 1);
      end
    end
    if (!coincide) begin
      waitClk(HALF);
      cs = 1'b1;
    end
    waitClk(gap);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expQ.size() != 0; i++) waitClk(1);
    checkOutput("drain_queue_empty", expQ.size(), 0);
    waitClk(4);
  endtask

  function automatic logic [FB-1:0] randWord();
    logic [FB-1:0] w;
    for (int i = 0; i < FB / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_error)) begin
      exp_t e;
      strobes++;
      checkOutput("strobe_exclusive", frame_valid & frame_error, 0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe: got valid=%0b error=%0b expected none",
                 frame_valid, frame_error);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("strobe_kind_frame%0d", e.id), frame_valid, e.isValid);
        checkOutput($sformatf("data_frame%0d", e.id), data_out, e.data);
      end
    end
    if (rst_n && prevRst && !frame_valid && data_out !== prevData) stabBad++;
    prevData = data_out;
    prevRst  = rst_n;
  end

  initial begin
    logic [FB-1:0] w;
    int            nb;
    cs    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    rst_n = 1'b0;
    waitClk(3);
    #1;
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_frame_valid", frame_valid, 0);
    checkOutput("reset_frame_error", frame_error, 0);
    checkOutput("reset_busy", busy, 0);
    rst_n = 1'b1;
    waitClk(8);

    applyStimulus({32{8'hA5}}, FB, 1'b0, 20);
    drain();
    checkOutput("a5_data_out", data_out, {32{8'hA5}});
    checkOutput("a5_busy_after", busy, 0);

    for (int k = 0; k < 16; k++) w[FB-1-16*k -: 16] = 16'(k);
    applyStimulus(w, FB, 1'b0, SS + 3);
    applyStimulus({FB{1'b1}}, FB, 1'b0, 20);
    drain();
    w = data_out;
    checkOutput("ones_top_bin", w[255:240], 16'hFFFF);

    applyStimulus(randWord(), FB - 1, 1'b0, 20);
    applyStimulus(randWord(), FB + 1, 1'b0, 20);
    applyStimulus(randWord(), FB, 1'b0, 20);
    drain();

    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(0, 3);
      nb = (nb == 3) ? FB : FB - 1 + nb;
      applyStimulus(randWord(), nb, 1'b0, SS + 3 + $urandom_range(0, 6));
    end
    drain();

    w = randWord();
    applyStimulus(w, FB, 1'b1, 20);
    drain();
    checkOutput("coincide_last_bit", data_out[0], w[0]);

    // CS held low through reset: the partial frame must be ignored.
    cs    = 1'b0;
    rst_n = 1'b0;
    waitClk(3);
    rst_n    = 1'b1;
    lastGood = '0;
    waitClk(HALF);
    for (int i = 0; i < 100; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
    waitClk(HALF);
    cs = 1'b1;
    waitClk(20);
    checkOutput("cs_low_reset_data", data_out, 0);

    applyStimulus(randWord(), FB, 1'b0, 20);
    drain();

    // Reset asserted halfway through a frame.
    cs = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < 128; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data_out", data_out, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_valid", frame_valid, 0);
    lastGood = '0;
    waitClk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) sendBit(1'($urandom_range(0, 1)), 1'b0);
    waitClk(HALF);
    cs = 1'b1;
    waitClk(20);
    checkOutput("midreset_no_strobe_data", data_out, 0);

    applyStimulus(randWord(), FB, 1'b0, 20);
    drain();

    checkOutput("strobe_count", strobes, pushed);
    checkOutput("data_stable_between_valid", stabBad, 0);
    checkOutput("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_spi_in.md
Name: fft_spi_in

Overview:
- SPI slave receiver; the far-end counterpart of fft_spi_out.
- Captures one FRAME_BITS-wide frame (default 256 bits = 16 FFT bins x 16 bits) from an external SPI master and presents it as a parallel bus with a one-cycle valid strobe.
- Used for board loopback of the FFT output path, and for loading frames from the Arduino side into the FPGA.
- Fully synchronous to the 16 MHz system clock; SCLK, MOSI and CS are oversampled, never used as clocks.

Parameters:
- FRAME_BITS, 256, bits per frame; also the data_out width.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- clk, input, 1, system clock, 16 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- sclk, input, 1, SPI clock from the master; must be at most clk/4.
- mosi, input, 1, serial data, MSB first.
- cs, input, 1, chip select, active low.
- data_out, output, FRAME_BITS, last complete frame; first received bit is at data_out[FRAME_BITS-1].
- frame_valid, output, 1, one-cycle pulse when data_out updates.
- frame_error, output, 1, one-cycle pulse on a short or long frame.
- busy, output, 1, high while a frame is being received.

Behaviour:
- Protocol: SPI mode 0.
  - CS idles high. MOSI is sampled on the SCLK rising edge. SCLK idles low.
  - A frame is one CS low period.
- Reset: all of the following are forced immediately, and the block returns to IDLE.
  - data_out = 0, frame_valid = 0, frame_error = 0, busy = 0.
  - Shift register = 0, bit counter = 0.
  - sclk and mosi synchronizers = 0; cs synchronizer = 1.
- Synchronizers: SYNC_STAGES flops per input, followed by one extra register for edge detection.
  - sclk_rise = sync high and previous value low.
  - cs_fall and cs_rise are derived the same way.
  - Latency from a pin edge to its detected event is SYNC_STAGES+1 clk cycles.
- State machine:
  - IDLE:
    - busy = 0.
    - On cs_fall: clear the bit counter and the overflow flag, then go to RECV.
    - If cs is low on exit from reset, stay in IDLE until a cs_fall is seen. A partial frame is never accepted.
  - RECV:
    - busy = 1.
    - On sclk_rise: shift = {shift[FRAME_BITS-2:0], mosi_sync}. The sample is aligned with the sclk sync stage.
    - Each sclk_rise increments the bit counter.
    - When the counter is already FRAME_BITS, a further sclk_rise sets the overflow flag. The counter saturates and the shift register still shifts.
    - On cs_rise, go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
    - If count == FRAME_BITS and no overflow: data_out <= shift and frame_valid = 1.
    - Otherwise: frame_error = 1 and data_out holds its previous value.
- Simultaneous sclk_rise and cs_rise in the same cycle: shift the bit first, then evaluate in DONE. The shift is counted.
- A cs_fall while in DONE is not lost; it is taken on the following IDLE cycle.
  - Minimum CS high time is therefore SYNC_STAGES+3 clk cycles.
- Counter width: $clog2(FRAME_BITS+1).
- frame_valid and frame_error are mutually exclusive and each lasts exactly one cycle.
- data_out is stable between frame_valid pulses.
- Asserting rst_n low mid-frame discards the frame. No strobe is generated for it.

Decomposition:
- Shared package fft_spi_pkg holds:
  - FRAME_BITS default (256) and BIN_WIDTH (16).
  - The SPI mode constant.
  - The state enum {IDLE, RECV, DONE}.
  - fft_spi_out uses the same package.
- One natural sub-module: spi_sync_edge.
  - Parameterised synchronizer plus edge detector.
  - Outputs level, rise and fall.
  - Instantiated three times, with reset value 1 for cs and 0 for the others.

Test Plan:
- Reset, then one 256-bit frame with 0xA5 repeated and SCLK = clk/8.
  - Expect one frame_valid pulse; data_out = {32{8'hA5}}; frame_error never high; busy low afterwards.
- Two back-to-back frames with CS high for SYNC_STAGES+3 cycles: an incrementing 16-bit pattern 0x0000..0x000F, then all-ones.
  - Expect two frame_valid pulses; data_out[255:240] = 0x0000 and then 0xFFFF.
- Short frame of 255 bits.
  - Expect frame_error for one cycle, no frame_valid, and data_out equal to the previous frame.
- Long frame of 257 bits.
  - Expect frame_error and data_out unchanged.
  - A following valid 256-bit frame is received correctly.
- Start with CS low during reset, release rst_n, clock 100 bits, then raise CS.
  - Expect no strobes.
- Assert rst_n low at bit 128 of a frame.
  - Expect data_out = 0 and busy = 0 immediately; no strobe is generated.
- The last SCLK rising edge coincides with the CS rise at the pins.
  - Expect frame_valid, with the last bit at data_out[0].
